// File: rtl/dsc_pkg.sv
// Shared definitions for the deterministic stochastic-computing multiplier.
//   dsc_state_e : control FSM states (IDLE, RUN, DONE)
//   dsc_out_w   : product / operand-bus width for n operands of b bits
//   dsc_cyc_w   : width of the cycle counter; one bit wider than the product so
//                 that the full run length 2**(n*b) fits
package dsc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } dsc_state_e;

  function automatic int dsc_out_w(input int n, input int b);
    return n * b;
  endfunction

  function automatic int dsc_cyc_w(input int n, input int b);
    return dsc_out_w(n, b) + 32'sd1;
  endfunction

endpackage

// File: rtl/dsc_sn_gen.sv
// One odometer stage of the DSC multiplier: a NUM_BITS counter plus a comparator.
//   clk, rst   : clock, synchronous active-high reset
//   en         : clock enable, 0 freezes the counter
//   clr        : synchronous clear of the counter (takes priority over counting)
//   op         : latched operand for this stage
//   carry_in   : advance request from the lower stages (all lower stages at max)
//   sn         : unary stream bit, op > counter
//   carry_out  : advance request for the next stage
module dsc_sn_gen import dsc_pkg::*; #(
  parameter int NUM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clr,
  input  logic [NUM_BITS-1:0] op,
  input  logic                carry_in,
  output logic                sn,
  output logic                carry_out
);

  localparam logic [NUM_BITS-1:0] C_MAX  = {NUM_BITS{1'b1}};
  localparam logic [NUM_BITS-1:0] C_ZERO = {NUM_BITS{1'b0}};
  localparam logic [NUM_BITS-1:0] C_ONE  = NUM_BITS'(1);

  logic [NUM_BITS-1:0] c_q;
  logic [NUM_BITS-1:0] c_d;

  // Next counter value: clear, advance (wrapping at max), or hold.
  always_comb begin
    c_d = c_q;
    if (clr) begin
      c_d = C_ZERO;
    end else if (carry_in) begin
      c_d = c_q + C_ONE;
    end else begin
      c_d = c_q;
    end
  end

  // Counter register, frozen while en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_q <= C_ZERO;
    end else if (en) begin
      c_q <= c_d;
    end else begin
      c_q <= c_q;
    end
  end

  assign sn        = (op > c_q);
  // The next stage only advances when this stage wraps.
  assign carry_out = carry_in & (c_q == C_MAX);

endmodule

// File: rtl/dsc_mul_n.sv
// Deterministic stochastic-computing multiplier: exact product of NUM_INPUTS
// unsigned NUM_BITS operands, computed over 2**(NUM_INPUTS*NUM_BITS) RUN cycles
// by ANDing odometer-ordered unary streams and counting the 1s.
//   clk, rst : clock, synchronous active-high reset
//   en       : clock enable, 0 freezes all state and ignores start
//   start    : operation request, accepted in IDLE or DONE
//   a        : operands, operand k = a[k*NUM_BITS +: NUM_BITS]
//   z        : product, valid while ov is high
//   ov       : done flag, high in DONE
//   busy     : high in RUN
//   cycles   : RUN cycles spent on the last/current operation
module dsc_mul_n import dsc_pkg::*; #(
  parameter int NUM_INPUTS = 4,
  parameter int NUM_BITS   = 8,
  parameter bit EARLY_ZERO = 1'b1
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          en,
  input  logic                                          start,
  input  logic [dsc_out_w(NUM_INPUTS, NUM_BITS)-1:0]    a,
  output logic [dsc_out_w(NUM_INPUTS, NUM_BITS)-1:0]    z,
  output logic                                          ov,
  output logic                                          busy,
  output logic [dsc_cyc_w(NUM_INPUTS, NUM_BITS)-1:0]    cycles
);

  localparam int OUT_W = dsc_out_w(NUM_INPUTS, NUM_BITS);
  localparam int CYC_W = dsc_cyc_w(NUM_INPUTS, NUM_BITS);

  localparam logic [OUT_W-1:0]    Z_ZERO   = {OUT_W{1'b0}};
  localparam logic [OUT_W-1:0]    Z_ONE    = OUT_W'(1);
  localparam logic [CYC_W-1:0]    CYC_ZERO = {CYC_W{1'b0}};
  localparam logic [CYC_W-1:0]    CYC_ONE  = CYC_W'(1);
  localparam logic [NUM_BITS-1:0] OP_ZERO  = {NUM_BITS{1'b0}};

  dsc_state_e             state_q, state_d;
  logic [OUT_W-1:0]       op_q, op_d;
  logic [OUT_W-1:0]       z_q, z_d;
  logic [CYC_W-1:0]       cyc_q, cyc_d;
  logic                   ov_q, ov_d;
  logic                   busy_q, busy_d;

  logic                   clr_s;
  logic                   any_zero_s;
  logic                   hit_s;
  logic                   all_max_s;
  logic [NUM_INPUTS-1:0]  sn_s;
  logic [NUM_INPUTS:0]    carry_s;

  // Flags a zero among the incoming operands for the early-exit path.
  always_comb begin
    any_zero_s = 1'b0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (a[k*NUM_BITS +: NUM_BITS] == OP_ZERO) begin
        any_zero_s = 1'b1;
      end else begin
        any_zero_s = any_zero_s;
      end
    end
  end

  // Stage 0 advances on every RUN cycle; higher stages ripple via carries.
  assign carry_s[0] = (state_q == ST_RUN);

  genvar gk;
  generate
    for (gk = 0; gk < NUM_INPUTS; gk++) begin : g_stage
      dsc_sn_gen #(
        .NUM_BITS (NUM_BITS)
      ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clr       (clr_s),
        .op        (op_q[gk*NUM_BITS +: NUM_BITS]),
        .carry_in  (carry_s[gk]),
        .sn        (sn_s[gk]),
        .carry_out (carry_s[gk+1])
      );
    end
  endgenerate

  assign hit_s     = &sn_s;
  // Final carry is set only in RUN with every counter at max: the last RUN cycle.
  assign all_max_s = carry_s[NUM_INPUTS];

  // FSM next-state and datapath next values.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    z_d     = z_q;
    cyc_d   = cyc_q;
    ov_d    = ov_q;
    busy_d  = busy_q;
    clr_s   = 1'b0;
    if (en) begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            op_d  = a;
            z_d   = Z_ZERO;
            cyc_d = CYC_ZERO;
            clr_s = 1'b1;
            if (EARLY_ZERO && any_zero_s) begin
              state_d = ST_DONE;
              ov_d    = 1'b1;
              busy_d  = 1'b0;
            end else begin
              state_d = ST_RUN;
              ov_d    = 1'b0;
              busy_d  = 1'b1;
            end
          end else begin
            state_d = state_q;
          end
        end
        ST_RUN: begin
          if (hit_s) begin
            z_d = z_q + Z_ONE;
          end else begin
            z_d = z_q;
          end
          cyc_d = cyc_q + CYC_ONE;
          if (all_max_s) begin
            state_d = ST_DONE;
            ov_d    = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_IDLE;
          z_d     = Z_ZERO;
          cyc_d   = CYC_ZERO;
          ov_d    = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= Z_ZERO;
      z_q     <= Z_ZERO;
      cyc_q   <= CYC_ZERO;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      z_q     <= z_d;
      cyc_q   <= cyc_d;
      ov_q    <= ov_d;
      busy_q  <= busy_d;
    end
  end

  assign z      = z_q;
  assign ov     = ov_q;
  assign busy   = busy_q;
  assign cycles = cyc_q;

endmodule

// File: tb/tb_dsc_mul_n.sv
// Scoreboard bench for dsc_mul_n. Three instances:
//   dut0: 2 x 4 bits, early zero on
//   dut1: 2 x 4 bits, early zero off
//   dut2: 4 x 2 bits, early zero on
// Stimulus pushes the expected (z, cycles) after each accepted start; a monitor
// pops and compares whenever a DUT shows ov with a result outstanding.
module tb_dsc_mul_n;

  typedef struct {
    int z;
    int cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_s   [3];
  logic       en_s    [3];
  logic       start_s [3];
  logic [7:0] a_s     [3];
  logic [7:0] z_s     [3];
  logic       ov_s    [3];
  logic       busy_s  [3];
  logic [8:0] cyc_s   [3];

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dsc_mul_n #(.NUM_INPUTS(2), .NUM_BITS(4), .EARLY_ZERO(1'b1)) dut0 (
    .clk(clk), .rst(rst_s[0]), .en(en_s[0]), .start(start_s[0]), .a(a_s[0]),
    .z(z_s[0]), .ov(ov_s[0]), .busy(busy_s[0]), .cycles(cyc_s[0]));

  dsc_mul_n #(.NUM_INPUTS(2), .NUM_BITS(4), .EARLY_ZERO(1'b0)) dut1 (
    .clk(clk), .rst(rst_s[1]), .en(en_s[1]), .start(start_s[1]), .a(a_s[1]),
    .z(z_s[1]), .ov(ov_s[1]), .busy(busy_s[1]), .cycles(cyc_s[1]));

  dsc_mul_n #(.NUM_INPUTS(4), .NUM_BITS(2), .EARLY_ZERO(1'b1)) dut2 (
    .clk(clk), .rst(rst_s[2]), .en(en_s[2]), .start(start_s[2]), .a(a_s[2]),
    .z(z_s[2]), .ov(ov_s[2]), .busy(busy_s[2]), .cycles(cyc_s[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compare the oldest outstanding result whenever ov is high.
  exp_t mon_e;
  bit   mon_got;
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (ov_s[d] === 1'b1) begin
        mon_got = 1'b0;
        case (d)
          0: if (q0.size() > 0) begin mon_e = q0.pop_front(); mon_got = 1'b1; end
          1: if (q1.size() > 0) begin mon_e = q1.pop_front(); mon_got = 1'b1; end
          default: if (q2.size() > 0) begin mon_e = q2.pop_front(); mon_got = 1'b1; end
        endcase
        if (mon_got) begin
          chk($sformatf("dut%0d_z", d), 32'(z_s[d]), mon_e.z);
          chk($sformatf("dut%0d_cycles", d), 32'(cyc_s[d]), mon_e.cyc);
        end
      end
    end
  end

  function automatic logic [7:0] pk2(input int hi, input int lo);
    logic [3:0] h;
    logic [3:0] l;
    h = hi[3:0];
    l = lo[3:0];
    return {h, l};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int d, input int ez, input int ec);
    exp_t e;
    e.z   = ez;
    e.cyc = ec;
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Drive start for one cycle; returns just after the accept edge.
  task automatic do_start(input int d, input logic [7:0] a, input int ez, input int ec,
                          input bit track);
    a_s[d]     = a;
    start_s[d] = 1'b1;
    @(negedge clk);
    start_s[d] = 1'b0;
    if (track) push(d, ez, ec);
  endtask

  // Count falling edges until ov is seen, bounded.
  task automatic wait_ov(input int d, input int bound, output int n);
    n = 0;
    while (ov_s[d] !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (ov_s[d] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL dut%0d_timeout: no ov after %0d cycles", d, bound);
    end
  endtask

  int         n;
  logic [7:0] r;
  int         p;

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_s[d]   = 1'b1;
      en_s[d]    = 1'b1;
      start_s[d] = 1'b0;
      a_s[d]     = 8'd0;
    end
    tick(3);
    for (int d = 0; d < 3; d++) rst_s[d] = 1'b0;

    // Reset state.
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst%0d_z", d), 32'(z_s[d]), 0);
      chk($sformatf("rst%0d_ov", d), 32'(ov_s[d]), 0);
      chk($sformatf("rst%0d_busy", d), 32'(busy_s[d]), 0);
      chk($sformatf("rst%0d_cycles", d), 32'(cyc_s[d]), 0);
    end

    // Zero operand with early exit: done right at the accept edge.
    do_start(0, pk2(9, 0), 0, 0, 1'b1);
    wait_ov(0, 400, n);
    chk("ez_latency", n, 0);
    tick(1);

    // Zero operand without early exit: full run, z stays 0.
    do_start(1, pk2(9, 0), 0, 256, 1'b1);
    chk("noez_busy", 32'(busy_s[1]), 1);
    wait_ov(1, 400, n);
    chk("noez_latency", n, 256);
    tick(1);

    // Both operands at max.
    do_start(0, pk2(15, 15), 225, 256, 1'b1);
    chk("max_busy", 32'(busy_s[0]), 1);
    chk("max_ov_low", 32'(ov_s[0]), 0);
    wait_ov(0, 400, n);
    chk("max_latency", n, 256);
    chk("max_busy_done", 32'(busy_s[0]), 0);
    tick(1);

    // Pause mid-RUN for 40 cycles.
    do_start(0, pk2(11, 7), 77, 256, 1'b1);
    tick(50);
    en_s[0] = 1'b0;
    tick(40);
    chk("pause_cycles", 32'(cyc_s[0]), 50);
    chk("pause_busy", 32'(busy_s[0]), 1);
    en_s[0] = 1'b1;
    wait_ov(0, 400, n);
    chk("pause_latency", n + 90, 296);
    tick(1);

    // Reset mid-RUN at RUN cycle 100.
    do_start(0, pk2(5, 5), 0, 0, 1'b0);
    tick(99);
    rst_s[0] = 1'b1;
    tick(1);
    rst_s[0] = 1'b0;
    chk("abort_z", 32'(z_s[0]), 0);
    chk("abort_ov", 32'(ov_s[0]), 0);
    chk("abort_busy", 32'(busy_s[0]), 0);
    chk("abort_cycles", 32'(cyc_s[0]), 0);

    // Reset and start together: reset wins.
    a_s[0]     = pk2(3, 3);
    rst_s[0]   = 1'b1;
    start_s[0] = 1'b1;
    tick(1);
    rst_s[0]   = 1'b0;
    start_s[0] = 1'b0;
    chk("rst_start_busy", 32'(busy_s[0]), 0);

    // Restart after abort.
    do_start(0, pk2(4, 3), 12, 256, 1'b1);
    wait_ov(0, 400, n);
    chk("restart_latency", n, 256);
    tick(1);

    // Start re-pulsed and operands changed during RUN are ignored.
    do_start(0, pk2(7, 6), 42, 256, 1'b1);
    tick(20);
    a_s[0]     = pk2(1, 1);
    start_s[0] = 1'b1;
    tick(1);
    start_s[0] = 1'b0;
    chk("repulse_busy", 32'(busy_s[0]), 1);
    wait_ov(0, 400, n);
    chk("repulse_latency", n + 21, 256);

    // Start held in DONE: accepted on the very next edge.
    do_start(0, pk2(3, 2), 6, 256, 1'b1);
    chk("b2b_ov_low", 32'(ov_s[0]), 0);
    chk("b2b_busy", 32'(busy_s[0]), 1);
    wait_ov(0, 400, n);
    chk("b2b_latency", n, 256);
    tick(1);

    // 4 x 2-bit operands, random vectors.
    for (int i = 0; i < 100; i++) begin
      r = 8'($urandom_range(0, 255));
      p = int'(r[1:0]) * int'(r[3:2]) * int'(r[5:4]) * int'(r[7:6]);
      do_start(2, r, p, (p == 0) ? 0 : 256, 1'b1);
      wait_ov(2, 400, n);
      chk($sformatf("rand%0d_latency", i), n, (p == 0) ? 0 : 256);
      tick(1);
    end

    tick(2);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
